// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
// Generates the registered DTACK for the 68000 from the region selects produced
// by the address decoder. Every bus cycle is latched at its start edge and then
// handled by one wait strategy: a fixed wait for fast regions, an SDRAM
// request/acknowledge handshake for program ROM reads, an arbitration wait for
// the Z80 shared RAM, or a watchdog for unmapped addresses. Any cycle that never
// gets a response ends with an open-bus DTACK, so the CPU cannot hang.
// All outputs are registered. A new cycle may start only after the machine has
// spent at least one IDLE edge with AS high. This keeps a cycle that was
// interrupted by reset, or that ended in an abort, from being acknowledged.

module m68k_bus_responder #(
  parameter int FAST_WAIT   = 1,    // extra wait cycles for fast_cs regions
  parameter int SHARED_WAIT = 2,    // wait cycles after the shared RAM is granted
  parameter int TIMEOUT     = 255,  // watchdog length for unmapped or unanswered ROM
  parameter int CNT_W       = 8     // counter width; every count must fit
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_as_n,
  input  logic       cpu_rw,
  input  logic [1:0] cpu_ds_n,
  input  logic       rom_cs,
  input  logic       shared_cs,
  input  logic       fast_cs,
  input  logic       shared_busy,
  input  logic       rom_ack,
  output logic       rom_req,
  output logic       cpu_dtack_n,
  output logic       open_bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_FAST   = 3'd1,
    W_ROM    = 3'd2,
    W_SHBUSY = 3'd3,
    W_SHARED = 3'd4,
    W_UNMAP  = 3'd5,
    ACK      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] FAST_LD    = CNT_W'(FAST_WAIT);
  localparam logic [CNT_W-1:0] SHARED_LD  = CNT_W'(SHARED_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             armed, armed_nxt;
  logic             dtack_nxt;
  logic             req_nxt;
  logic             open_nxt;

  logic             as_low;
  logic             start;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_dec;

  // Strobe qualification and the saturating counter step.
  always_comb begin
    as_low   = ~cpu_as_n;
    start    = armed & as_low & (cpu_ds_n != 2'b11);
    cnt_zero = (cnt == '0);
    cnt_dec  = cnt_zero ? '0 : cnt - 1'b1;
  end

  // Next-state and next-output logic. The outputs are registered, so each value
  // computed here becomes visible one edge after the decision that produces it.
  always_comb begin
    // NOTE: every signal gets a default first. Any path that leaves one unassigned would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed;
    dtack_nxt = 1'b1;
    req_nxt   = 1'b0;
    open_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        // Arm only after an IDLE edge sees AS high. A strobe still low from an
        // earlier cycle or from reset must never start a new cycle.
        if (cpu_as_n) begin
          armed_nxt = 1'b1;
        end
        if (start) begin
          armed_nxt = 1'b0;
          if (rom_cs && cpu_rw) begin
            state_nxt = W_ROM;
            cnt_nxt   = TIMEOUT_LD;
            req_nxt   = 1'b1;
          end else if (shared_cs) begin
            state_nxt = W_SHBUSY;
          end else if (fast_cs || rom_cs) begin
            // A ROM write has nothing to fetch, so it completes like a fast access.
            state_nxt = W_FAST;
            cnt_nxt   = FAST_LD;
          end else begin
            state_nxt = W_UNMAP;
            cnt_nxt   = TIMEOUT_LD;
          end
        end
      end

      W_FAST: begin
        if (cpu_as_n) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = ACK;
          dtack_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      W_ROM: begin
        // An acknowledge wins over the watchdog when both occur at the same edge.
        if (cpu_as_n) begin
          state_nxt = IDLE;
        end else if (rom_ack) begin
          state_nxt = ACK;
          dtack_nxt = 1'b0;
        end else if (cnt_zero) begin
          state_nxt = ACK;
          dtack_nxt = 1'b0;
          open_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
          req_nxt = 1'b1;
        end
      end

      W_SHBUSY: begin
        // No watchdog here: a Z80 access to the shared RAM always finishes.
        if (cpu_as_n) begin
          state_nxt = IDLE;
        end else if (!shared_busy) begin
          state_nxt = W_SHARED;
          cnt_nxt   = SHARED_LD;
        end
      end

      W_SHARED: begin
        // Once the port is granted, shared_busy is no longer checked.
        if (cpu_as_n) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = ACK;
          dtack_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      W_UNMAP: begin
        if (cpu_as_n) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = ACK;
          dtack_nxt = 1'b0;
          open_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      ACK: begin
        // Hold DTACK and the open-bus flag until the CPU releases AS.
        if (cpu_as_n) begin
          state_nxt = IDLE;
        end else begin
          dtack_nxt = 1'b0;
          open_nxt  = open_bus;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs. Reset overrides any cycle in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      cpu_dtack_n <= 1'b1;
      rom_req     <= 1'b0;
      open_bus    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      armed       <= armed_nxt;
      cpu_dtack_n <= dtack_nxt;
      rom_req     <= req_nxt;
      open_bus    <= open_nxt;
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder
// Drives 68000 bus cycles into m68k_bus_responder. For each cycle the bench
// works out the DTACK latency, the ROM request window and the open-bus flag
// directly from the region rules, then checks the outputs at every edge.
// Inputs change 1 ns after each rising edge. Outputs are sampled at the same
// point, so "obs j" means the value registered at the j-th edge after the
// start edge.

module tb_m68k_bus_responder;

  localparam int FAST_WAIT   = 1;
  localparam int SHARED_WAIT = 2;
  localparam int TIMEOUT     = 255;
  localparam int CNT_W       = 8;

  localparam int K_FAST   = 0;
  localparam int K_ROM    = 1;
  localparam int K_SHARED = 2;
  localparam int K_UNMAP  = 3;

  logic       clk;
  logic       reset;
  logic       cpu_as_n;
  logic       cpu_rw;
  logic [1:0] cpu_ds_n;
  logic       rom_cs;
  logic       shared_cs;
  logic       fast_cs;
  logic       shared_busy;
  logic       rom_ack;
  logic       rom_req;
  logic       cpu_dtack_n;
  logic       open_bus;

  int checks = 0;
  int errors = 0;

  m68k_bus_responder #(
    .FAST_WAIT  (FAST_WAIT),
    .SHARED_WAIT(SHARED_WAIT),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_as_n   (cpu_as_n),
    .cpu_rw     (cpu_rw),
    .cpu_ds_n   (cpu_ds_n),
    .rom_cs     (rom_cs),
    .shared_cs  (shared_cs),
    .fast_cs    (fast_cs),
    .shared_busy(shared_busy),
    .rom_ack    (rom_ack),
    .rom_req    (rom_req),
    .cpu_dtack_n(cpu_dtack_n),
    .open_bus   (open_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Region chosen by the select priority ROM read > shared > fast/ROM write > none.
  function automatic int classify(input logic rom, input logic sh, input logic fst, input logic rw);
    if (rom && rw) return K_ROM;
    if (sh)        return K_SHARED;
    if (fst || rom) return K_FAST;
    return K_UNMAP;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete bus cycle, checked at every edge.
  //  ack_at   : edge (after start) where rom_ack first goes high; 0 = never
  //  busy_for : number of W_SHBUSY edges that still see shared_busy high
  //  abort_at : edge where AS is seen high before DTACK; 0 = no abort
  //  hold     : extra ACK edges before the CPU releases AS
  task automatic run_cycle(input string name, input logic rom, input logic sh,
                           input logic fst, input logic rw, input int ack_at,
                           input bit ack_level, input int busy_for,
                           input int abort_at, input int hold);
    int   kind;
    int   exp_j;
    int   rel;
    int   req_end;
    bit   exp_open;
    bit   aborted;
    logic exp_dtack;
    logic exp_req;
    logic exp_ob;

    kind     = classify(rom, sh, fst, rw);
    exp_open = 1'b0;
    case (kind)
      K_FAST:   exp_j = FAST_WAIT + 1;
      K_ROM: begin
        if (ack_at >= 1 && ack_at <= TIMEOUT + 1) begin
          exp_j = ack_at;
        end else begin
          exp_j    = TIMEOUT + 1;
          exp_open = 1'b1;
        end
      end
      K_SHARED: exp_j = busy_for + 1 + SHARED_WAIT + 1;
      default: begin
        exp_j    = TIMEOUT + 1;
        exp_open = 1'b1;
      end
    endcase
    aborted = (abort_at > 0) && (abort_at < exp_j);
    rel     = aborted ? abort_at : exp_j + 1 + hold;
    req_end = aborted ? abort_at : exp_j;

    cpu_as_n    = 1'b0;
    cpu_ds_n    = 2'($urandom_range(0, 2));
    cpu_rw      = rw;
    rom_cs      = rom;
    shared_cs   = sh;
    fast_cs     = fst;
    rom_ack     = 1'b0;
    shared_busy = 1'($urandom);
    step();

    for (int j = 0; j <= rel + 1; j++) begin
      exp_dtack = (!aborted && j >= exp_j && j < rel) ? 1'b0 : 1'b1;
      exp_ob    = !exp_dtack && exp_open;
      exp_req   = (kind == K_ROM) && (j < req_end);

      checks++;
      if (cpu_dtack_n !== exp_dtack) begin
        errors++;
        $display("FAIL %s dtack_n obs %0d: got %b expected %b", name, j, cpu_dtack_n, exp_dtack);
      end
      checks++;
      if (rom_req !== exp_req) begin
        errors++;
        $display("FAIL %s rom_req obs %0d: got %b expected %b", name, j, rom_req, exp_req);
      end
      checks++;
      if (open_bus !== exp_ob) begin
        errors++;
        $display("FAIL %s open_bus obs %0d: got %b expected %b", name, j, open_bus, exp_ob);
      end

      // Mid-cycle select changes must be ignored.
      rom_cs    = 1'($urandom);
      shared_cs = 1'($urandom);
      fast_cs   = 1'($urandom);
      cpu_rw    = 1'($urandom);
      if (kind == K_ROM) begin
        rom_ack = ((j + 1) == ack_at) ||
                  (ack_level && ack_at > 0 && (j + 1) > ack_at && (j + 1) < rel);
      end else begin
        rom_ack = 1'($urandom);
      end
      if ((j + 1) <= busy_for)          shared_busy = 1'b1;
      else if ((j + 1) == busy_for + 1) shared_busy = 1'b0;
      else                              shared_busy = 1'($urandom);
      cpu_as_n = ((j + 1) >= rel) ? 1'b1 : 1'b0;
      step();
    end
    rom_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cpu_as_n  = 1'b0;
    cpu_ds_n  = 2'b00;
    cpu_rw    = 1'b1;
    rom_cs    = 1'b1;
    shared_cs = 1'b0;
    fast_cs   = 1'b1;
    shared_busy = 1'b0;
    rom_ack   = 1'b0;
    repeat (3) step();
    checks++;
    if (cpu_dtack_n !== 1'b1 || rom_req !== 1'b0 || open_bus !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got dtack_n=%b rom_req=%b open_bus=%b expected 1/0/0",
               cpu_dtack_n, rom_req, open_bus);
    end
    reset    = 1'b0;
    cpu_as_n = 1'b1;
    cpu_ds_n = 2'b11;
    step();
    checks++;
    if (cpu_dtack_n !== 1'b1 || rom_req !== 1'b0) begin
      errors++;
      $display("FAIL reset release: got dtack_n=%b rom_req=%b expected 1/0", cpu_dtack_n, rom_req);
    end
  endtask

  task automatic test_fast();
    run_cycle("fast_read",  1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0, 2);
    run_cycle("fast_write", 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
    run_cycle("rom_write",  1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1);
  endtask

  task automatic test_rom_ack();
    run_cycle("rom_ack10",      1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 0, 0, 1);
    run_cycle("rom_ack1_level", 1'b1, 1'b1, 1'b1, 1'b1, 1,  1'b1, 0, 0, 0);
    run_cycle("rom_ack_edge",   1'b1, 1'b0, 1'b0, 1'b1, TIMEOUT + 1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_rom_timeout();
    run_cycle("rom_timeout", 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 2);
  endtask

  task automatic test_shared();
    run_cycle("shared_busy5", 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 5, 0, 1);
    run_cycle("shared_free",  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
    run_cycle("shared_over_romwr", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2, 0, 0);
  endtask

  task automatic test_unmapped();
    run_cycle("unmapped", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 1);
  endtask

  // AS low without any data strobe must not start a cycle.
  task automatic test_ds_idle();
    cpu_as_n = 1'b0;
    cpu_ds_n = 2'b11;
    fast_cs  = 1'b1;
    rom_cs   = 1'b0;
    shared_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (cpu_dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL ds_idle obs %0d: got dtack_n=%b expected 1", i, cpu_dtack_n);
      end
    end
    cpu_as_n = 1'b1;
    repeat (2) step();
  endtask

  // Abort mid-ROM wait, late ack lands in IDLE, then a fast cycle at nominal latency.
  task automatic test_abort_late_ack();
    run_cycle("abort_rom",      1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0, 0, 3, 0);
    run_cycle("after_abort",    1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0, 0);
    run_cycle("abort_shared",   1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 4, 2, 0);
    run_cycle("abort_fast",     1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic r, s, f, w;
    int   ack_at;
    int   abort_at;
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom);
      s = 1'($urandom);
      f = 1'($urandom);
      w = 1'($urandom);
      ack_at   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_cycle("random", r, s, f, w, ack_at, 1'($urandom),
                int'($urandom_range(0, 6)), abort_at, int'($urandom_range(0, 3)));
    end
  endtask

  // Reset while acknowledging a timed-out cycle, with AS still held low.
  task automatic test_reset_in_ack();
    int  seen_at;
    cpu_as_n  = 1'b0;
    cpu_ds_n  = 2'b00;
    cpu_rw    = 1'b1;
    rom_cs    = 1'b0;
    shared_cs = 1'b0;
    fast_cs   = 1'b0;
    step();
    seen_at = -1;
    for (int j = 0; j < TIMEOUT + 10 && seen_at < 0; j++) begin
      if (cpu_dtack_n === 1'b0) seen_at = j;
      else step();
    end
    checks++;
    if (seen_at != TIMEOUT + 1) begin
      errors++;
      $display("FAIL reset_in_ack latency: got obs %0d expected %0d", seen_at, TIMEOUT + 1);
    end
    checks++;
    if (open_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ack open_bus before reset: got %b expected 1", open_bus);
    end
    reset = 1'b1;
    step();
    checks++;
    if (cpu_dtack_n !== 1'b1 || rom_req !== 1'b0 || open_bus !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ack outputs: got dtack_n=%b rom_req=%b open_bus=%b expected 1/0/0",
               cpu_dtack_n, rom_req, open_bus);
    end
    reset = 1'b0;
    fast_cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (cpu_dtack_n !== 1'b1 || rom_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ack stale AS obs %0d: got dtack_n=%b rom_req=%b expected 1/0",
                 i, cpu_dtack_n, rom_req);
      end
    end
    cpu_as_n = 1'b1;
    repeat (2) step();
    run_cycle("after_reset", 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fast();
    test_rom_ack();
    test_rom_timeout();
    test_shared();
    test_unmapped();
    test_ds_idle();
    test_abort_late_ack();
    test_random();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
